// File: rtl/sys_ctrl_burst.sv
// sys_ctrl_burst: parses UART command frames and drives the register file, ALU, ALU clock gate and TX FIFO.
// Ports:
//   clk, rst (async, active low)      REF_CLK domain clock and reset
//   RX_P_DATA / RX_D_VLD              received byte and its one-cycle strobe
//   WrEn, RdEn, address, WrData       register file write/read controls
//   RdData / RdData_Valid             register read return
//   ALU_FUN, EN, CLK_EN               ALU function, enable pulse and clock-gate enable
//   ALU_OUT / OUT_Valid               ALU result return
//   clk_div_en                        UART clock-divider enable, high from the first clock after reset
//   TX_P_DATA / TX_D_VLD, fifo_full   TX FIFO write port
//   frame_err                         one-cycle pulse on a protocol error or inter-byte timeout
module sys_ctrl_burst #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int FUN_WIDTH   = 4,
  parameter int ALU_BYTES   = 2,
  parameter int TO_WIDTH    = 10,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           RX_P_DATA,
  input  logic                            RX_D_VLD,
  output logic                            WrEn,
  output logic                            RdEn,
  output logic [ADDR_WIDTH-1:0]           address,
  output logic [DATA_WIDTH-1:0]           WrData,
  input  logic [DATA_WIDTH-1:0]           RdData,
  input  logic                            RdData_Valid,
  output logic [FUN_WIDTH-1:0]            ALU_FUN,
  output logic                            EN,
  input  logic [ALU_BYTES*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                            OUT_Valid,
  output logic                            CLK_EN,
  output logic                            clk_div_en,
  output logic [DATA_WIDTH-1:0]           TX_P_DATA,
  output logic                            TX_D_VLD,
  input  logic                            fifo_full,
  output logic                            frame_err
);
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
    ALU_FUNC, ALU_WAIT, BST_ADDR, BST_LEN, BST_DATA, TX_SEND
  } state_t;
  localparam int BW = ALU_BYTES * DATA_WIDTH;
  localparam int RW = $clog2(ALU_BYTES + 1);
  localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_FUN = DATA_WIDTH'(8'hDD);
  localparam logic [DATA_WIDTH-1:0] OP_BST = DATA_WIDTH'(8'hEE);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  en_q, en_d;
  logic                  en_sent_q, en_sent_d;
  logic                  clk_en_q, clk_en_d;
  logic                  clk_div_en_q;
  logic                  frame_err_q, frame_err_d;
  logic [BW-1:0]         tx_buf_q, tx_buf_d;
  logic [RW-1:0]         tx_rem_q, tx_rem_d;
  logic [DATA_WIDTH-1:0] bst_rem_q, bst_rem_d;
  logic                  bst_first_q, bst_first_d;
  logic [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
  logic                  in_frame, timed_out;
  // Only states that wait on the next RX byte are subject to the inter-byte timeout.
  assign in_frame  = state_q inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUNC,
                                     BST_ADDR, BST_LEN, BST_DATA};
  assign timed_out = in_frame && !RX_D_VLD && to_cnt_q == TO_WIDTH'(TIMEOUT_CYC);
  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    wr_data_d   = wr_data_q;
    alu_fun_d   = alu_fun_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    en_d        = 1'b0;
    en_sent_d   = en_sent_q;
    clk_en_d    = clk_en_q;
    frame_err_d = 1'b0;
    tx_buf_d    = tx_buf_q;
    tx_rem_d    = tx_rem_q;
    bst_rem_d   = bst_rem_q;
    bst_first_d = bst_first_q;
    to_cnt_d    = in_frame && !RX_D_VLD ? to_cnt_q + 1'b1 : '0;
    if (timed_out) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (RX_D_VLD) begin
          state_d     = RX_P_DATA == OP_WR  ? WR_ADDR  :
                        RX_P_DATA == OP_RD  ? RD_ADDR  :
                        RX_P_DATA == OP_ALU ? OP_A     :
                        RX_P_DATA == OP_FUN ? ALU_FUNC :
                        RX_P_DATA == OP_BST ? BST_ADDR : IDLE;
          frame_err_d = !(RX_P_DATA inside {OP_WR, OP_RD, OP_ALU, OP_FUN, OP_BST});
        end
        WR_ADDR: if (RX_D_VLD) begin
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = WR_DATA;
        end
        WR_DATA: if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end
        RD_ADDR: if (RX_D_VLD) begin
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d   = 1'b1;
          state_d   = RD_WAIT;
        end
        RD_WAIT: if (RdData_Valid) begin
          tx_buf_d                 = '0;
          tx_buf_d[DATA_WIDTH-1:0] = RdData;
          tx_rem_d                 = RW'(1);
          state_d                  = TX_SEND;
        end
        OP_A: if (RX_D_VLD) begin
          address_d = '0;
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = OP_B;
        end
        OP_B: if (RX_D_VLD) begin
          address_d = ADDR_WIDTH'(1);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ALU_FUNC;
        end
        ALU_FUNC: if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
          clk_en_d  = 1'b1;
          en_sent_d = 1'b0;
          state_d   = ALU_WAIT;
        end
        // EN is issued on the first ALU_WAIT cycle so it lands one cycle after the gated clock is running.
        ALU_WAIT: if (!en_sent_q) begin
          en_d      = 1'b1;
          en_sent_d = 1'b1;
        end else if (OUT_Valid) begin
          tx_buf_d = ALU_OUT;
          tx_rem_d = RW'(ALU_BYTES);
          clk_en_d = 1'b0;
          state_d  = TX_SEND;
        end
        BST_ADDR: if (RX_D_VLD) begin
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = BST_LEN;
        end
        BST_LEN: if (RX_D_VLD) begin
          frame_err_d = RX_P_DATA == '0;
          bst_rem_d   = RX_P_DATA;
          bst_first_d = 1'b1;
          state_d     = RX_P_DATA == '0 ? IDLE : BST_DATA;
        end
        // The first data byte uses the loaded address; each later one steps it, wrapping naturally.
        BST_DATA: if (RX_D_VLD) begin
          address_d   = bst_first_q ? address_q : address_q + 1'b1;
          wr_data_d   = RX_P_DATA;
          wr_en_d     = 1'b1;
          bst_first_d = 1'b0;
          bst_rem_d   = bst_rem_q - 1'b1;
          state_d     = bst_rem_q == DATA_WIDTH'(1) ? IDLE : BST_DATA;
        end
        TX_SEND: if (!fifo_full) begin
          tx_buf_d = tx_buf_q >> DATA_WIDTH;
          tx_rem_d = tx_rem_q - 1'b1;
          state_d  = tx_rem_q == RW'(1) ? IDLE : TX_SEND;
        end
        default: state_d = IDLE;
      endcase
    end
    if (RX_D_VLD && state_q inside {RD_WAIT, ALU_WAIT, TX_SEND}) frame_err_d = 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      address_q    <= '0;
      wr_data_q    <= '0;
      alu_fun_q    <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      en_q         <= 1'b0;
      en_sent_q    <= 1'b0;
      clk_en_q     <= 1'b0;
      clk_div_en_q <= 1'b0;
      frame_err_q  <= 1'b0;
      tx_buf_q     <= '0;
      tx_rem_q     <= '0;
      bst_rem_q    <= '0;
      bst_first_q  <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      wr_data_q    <= wr_data_d;
      alu_fun_q    <= alu_fun_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      en_q         <= en_d;
      en_sent_q    <= en_sent_d;
      clk_en_q     <= clk_en_d;
      clk_div_en_q <= 1'b1;
      frame_err_q  <= frame_err_d;
      tx_buf_q     <= tx_buf_d;
      tx_rem_q     <= tx_rem_d;
      bst_rem_q    <= bst_rem_d;
      bst_first_q  <= bst_first_d;
      to_cnt_q     <= to_cnt_d;
    end
  end
  assign WrEn       = wr_en_q;
  assign RdEn       = rd_en_q;
  assign address    = address_q;
  assign WrData     = wr_data_q;
  assign ALU_FUN    = alu_fun_q;
  assign EN         = en_q;
  assign CLK_EN     = clk_en_q;
  assign clk_div_en = clk_div_en_q;
  assign frame_err  = frame_err_q;
  // The FIFO write strobe follows fifo_full combinationally so a full FIFO never sees a write.
  assign TX_D_VLD   = state_q == TX_SEND && !fifo_full;
  assign TX_P_DATA  = tx_buf_q[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_sys_ctrl_burst.sv
// tb_sys_ctrl_burst: vector table, corner sequences and random frames against a frame-level model.
module tb_sys_ctrl_burst;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic        WrEn, RdEn, EN, CLK_EN, clk_div_en, TX_D_VLD, frame_err;
  logic [3:0]  address, ALU_FUN;
  logic [7:0]  WrData, TX_P_DATA;
  logic [7:0]  RdData = '0;
  logic        RdData_Valid = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_Valid = 1'b0;
  logic        fifo_full = 1'b0;
  int          n_cmp = 0, n_bad = 0, err_cnt = 0, en_cnt = 0;
  logic        prev_err = 1'b0;
  logic [11:0] wr_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  env_mem[16];

  sys_ctrl_burst dut (
    .clk(clk), .rst(rst), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .WrEn(WrEn), .RdEn(RdEn), .address(address), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_FUN(ALU_FUN), .EN(EN),
    .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid), .CLK_EN(CLK_EN), .clk_div_en(clk_div_en),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .fifo_full(fifo_full), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // External ALU: fun 0 adds the two operands, any other fun XORs them with the fun nibble.
  function automatic logic [15:0] alu_f(input logic [3:0] f, input logic [7:0] m0, input logic [7:0] m1);
    return f == 4'h0 ? {8'h0, m0} + {8'h0, m1} : {m0, m1} ^ {2{4'h0, f}};
  endfunction

  // Environment (register file + ALU responders) and output monitor, all away from the active edge.
  always @(negedge clk) begin
    RdData_Valid = 1'b0;
    OUT_Valid = 1'b0;
    if (WrEn) begin
      wr_q.push_back({address, WrData});
      env_mem[address] = WrData;
    end
    if (RdEn) begin
      RdData = env_mem[address];
      RdData_Valid = 1'b1;
    end
    if (EN) begin
      en_cnt++;
      chk("en_under_clk_en", 32'(CLK_EN), 1);
      ALU_OUT = alu_f(ALU_FUN, env_mem[0], env_mem[1]);
      OUT_Valid = 1'b1;
    end
    if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
    if (frame_err) begin
      err_cnt++;
      chk("err_one_cycle", 32'(prev_err), 0);
    end
    prev_err = frame_err;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    tick(1);
    RX_D_VLD = 1'b0;
  endtask

  task automatic clr();
    wr_q.delete();
    tx_q.delete();
    err_cnt = 0;
    en_cnt = 0;
  endtask

  typedef struct {
    logic [5:0][7:0] b;
    int              n;
    int              wr;
    int              tx;
    int              er;
    logic [11:0]     fw;
    logic [11:0]     lw;
    logic [7:0]      ft;
    logic [7:0]      lt;
  } vec_t;

  initial begin
    vec_t        v[10];
    logic [7:0]  a, d, fn, len;
    logic [7:0]  mm[16];
    logic [11:0] ew[$];
    logic [7:0]  et[$];
    logic [7:0]  fr[$];
    logic [15:0] r;
    int          ee, een, kind, k;
    v[0] = '{48'hAA053C000000, 3, 1, 0, 0, 12'h53C, 12'h53C, 8'h00, 8'h00};
    v[1] = '{48'hBB0500000000, 2, 0, 1, 0, 12'h000, 12'h000, 8'h3C, 8'h3C};
    v[2] = '{48'hCC0A03000000, 4, 2, 2, 0, 12'h00A, 12'h103, 8'h0D, 8'h00};
    v[3] = '{48'hEE0E03112233, 6, 3, 0, 0, 12'hE11, 12'h033, 8'h00, 8'h00};
    v[4] = '{48'h5A0000000000, 1, 0, 0, 1, 12'h000, 12'h000, 8'h00, 8'h00};
    v[5] = '{48'hEE0300000000, 3, 0, 0, 1, 12'h000, 12'h000, 8'h00, 8'h00};
    v[6] = '{48'hDD0100000000, 2, 0, 2, 0, 12'h000, 12'h000, 8'h02, 8'h32};
    v[7] = '{48'hBB0F00000000, 2, 0, 1, 0, 12'h000, 12'h000, 8'h22, 8'h22};
    v[8] = '{48'hBB1500000000, 2, 0, 1, 0, 12'h000, 12'h000, 8'h3C, 8'h3C};
    v[9] = '{48'hAA1E99000000, 3, 1, 0, 0, 12'hE99, 12'hE99, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) env_mem[i] = 8'(i * 17);
    tick(3);
    chk("rst_strobes", 32'({WrEn, RdEn, EN, CLK_EN, TX_D_VLD, frame_err, clk_div_en}), 0);
    chk("rst_address", 32'(address), 0);
    chk("rst_wrdata", 32'(WrData), 0);
    chk("rst_alufun", 32'(ALU_FUN), 0);
    chk("rst_txdata", 32'(TX_P_DATA), 0);
    rst = 1'b1;
    chk("clk_div_before_edge", 32'(clk_div_en), 0);
    tick(1);
    chk("clk_div_after_edge", 32'(clk_div_en), 1);

    for (int n = 0; n < 10; n++) begin
      clr();
      for (int i = 0; i < v[n].n; i++) send(v[n].b[5-i]);
      tick(12);
      chk($sformatf("v%0d_wr_count", n), wr_q.size(), v[n].wr);
      chk($sformatf("v%0d_tx_count", n), tx_q.size(), v[n].tx);
      chk($sformatf("v%0d_err_count", n), err_cnt, v[n].er);
      chk($sformatf("v%0d_clk_en_idle", n), 32'(CLK_EN), 0);
      if (v[n].wr > 0 && wr_q.size() > 0) begin
        chk($sformatf("v%0d_first_wr", n), 32'(wr_q[0]), 32'(v[n].fw));
        chk($sformatf("v%0d_last_wr", n), 32'(wr_q[$]), 32'(v[n].lw));
      end
      if (v[n].tx > 0 && tx_q.size() > 0) begin
        chk($sformatf("v%0d_first_tx", n), 32'(tx_q[0]), 32'(v[n].ft));
        chk($sformatf("v%0d_last_tx", n), 32'(tx_q[$]), 32'(v[n].lt));
      end
    end

    // Inter-byte timeout: WR_DATA waits 1000 idle cycles, the abort pulse appears on the next one.
    clr();
    send(8'hAA);
    send(8'h02);
    k = 0;
    @(negedge clk);
    while (!frame_err && k < 1100) begin
      k++;
      @(negedge clk);
    end
    chk("timeout_cycles", k, 1001);
    tick(2);
    chk("timeout_err", err_cnt, 1);
    chk("timeout_no_write", wr_q.size(), 0);
    send(8'hAA);
    send(8'h02);
    send(8'h77);
    tick(5);
    chk("after_timeout_wr_count", wr_q.size(), 1);
    if (wr_q.size() > 0) chk("after_timeout_wr", 32'(wr_q[0]), 32'h277);

    // Read reply stalled behind a full FIFO, with a byte dropped during the stall.
    clr();
    fifo_full = 1'b1;
    send(8'hBB);
    send(8'h01);
    tick(25);
    chk("full_no_tx", tx_q.size(), 0);
    send(8'hAA);
    tick(3);
    chk("drop_in_tx_err", err_cnt, 1);
    fifo_full = 1'b0;
    tick(5);
    chk("full_release_tx_count", tx_q.size(), 1);
    if (tx_q.size() > 0) chk("full_release_tx", 32'(tx_q[0]), 32'h03);
    chk("drop_no_new_frame", err_cnt, 1);

    // Reset in the middle of an ALU frame.
    clr();
    fifo_full = 1'b1;
    send(8'hDD);
    send(8'h00);
    chk("pre_rst_clk_en", 32'(CLK_EN), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_strobes", 32'({CLK_EN, EN, WrEn, RdEn, TX_D_VLD, clk_div_en}), 0);
    fifo_full = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(10);
    chk("mid_rst_no_tx", tx_q.size(), 0);
    chk("mid_rst_clk_div", 32'(clk_div_en), 1);

    // Random frames against the frame-level model.
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = 8'(i * 17);
      mm[i] = 8'(i * 17);
    end
    for (int f = 0; f < 150; f++) begin
      fr.delete();
      ew.delete();
      et.delete();
      ee = 0;
      een = 0;
      kind = $urandom_range(0, 5);
      a = 8'($urandom);
      d = 8'($urandom);
      fn = 8'($urandom);
      case (kind)
        0: begin
          fr.push_back(8'hAA); fr.push_back(a); fr.push_back(d);
          mm[a[3:0]] = d;
          ew.push_back({a[3:0], d});
        end
        1: begin
          fr.push_back(8'hBB); fr.push_back(a);
          et.push_back(mm[a[3:0]]);
        end
        2, 3: begin
          if (kind == 2) begin
            fr.push_back(8'hCC); fr.push_back(a); fr.push_back(d);
            mm[0] = a;
            mm[1] = d;
            ew.push_back({4'h0, a});
            ew.push_back({4'h1, d});
          end else fr.push_back(8'hDD);
          fr.push_back(fn);
          r = alu_f(fn[3:0], mm[0], mm[1]);
          et.push_back(r[7:0]);
          et.push_back(r[15:8]);
          een = 1;
        end
        4: begin
          len = 8'($urandom_range(0, 4));
          fr.push_back(8'hEE); fr.push_back(a); fr.push_back(len);
          if (len == 0) ee = 1;
          for (int j = 0; j < int'(len); j++) begin
            d = 8'($urandom);
            fr.push_back(d);
            mm[4'(a[3:0] + 4'(j))] = d;
            ew.push_back({4'(a[3:0] + 4'(j)), d});
          end
        end
        default: begin
          do d = 8'($urandom); while (d inside {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE});
          fr.push_back(d);
          ee = 1;
        end
      endcase
      clr();
      foreach (fr[j]) send(fr[j]);
      for (int c = 0; c < 30; c++) begin
        fifo_full = c < 22 && $urandom_range(0, 3) == 0;
        tick(1);
      end
      chk("rnd_wr_count", wr_q.size(), ew.size());
      chk("rnd_tx_count", tx_q.size(), et.size());
      chk("rnd_err_count", err_cnt, ee);
      chk("rnd_en_count", en_cnt, een);
      for (int j = 0; j < ew.size() && j < wr_q.size(); j++) chk("rnd_wr", 32'(wr_q[j]), 32'(ew[j]));
      for (int j = 0; j < et.size() && j < tx_q.size(); j++) chk("rnd_tx", 32'(tx_q[j]), 32'(et[j]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
